encoder_velocity_sampler: RTL and testbench

//   Periodic sampling scheduler for the free-running per-motor encoder quadrature counters.

---
 rtl/encoder_velocity_sampler_if.sv | 26 ++
 rtl/encoder_velocity_sampler.sv | 155 +++++++++++++++
 tb/tb_encoder_velocity_sampler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/encoder_velocity_sampler_if.sv
// Host-side readout bus of the encoder velocity sampler.
// The host (master) selects a channel, holds the bank with lock and clears overrun.
// The sampler (slave) returns committed deltas and status.
interface encoder_velocity_sampler_if #(
    parameter int COUNT_WIDTH = 15,
    parameter int ADDR_WIDTH  = 3
);
    logic                   lock;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [COUNT_WIDTH-1:0] rd_data;
    logic                   sample_valid;
    logic [7:0]             sample_seq;
    logic                   busy;
    logic                   overrun;
    logic                   ovr_clr;

    modport master (
        output lock, rd_addr, ovr_clr,
        input  rd_data, sample_valid, sample_seq, busy, overrun
    );

    modport slave (
        input  lock, rd_addr, ovr_clr,
        output rd_data, sample_valid, sample_seq, busy, overrun
    );
endinterface

// File: rtl/encoder_velocity_sampler.sv
// Periodic encoder sampler: every SAMPLE_PERIOD clocks it sweeps all channels,
// one per clock, computing the signed delta since the previous sweep, and then
// commits the full set to a readout bank once the host is not holding lock.
module encoder_velocity_sampler #(
    parameter int NUM_MOTORS    = 5,
    parameter int COUNT_WIDTH   = 15,
    parameter int SAMPLE_PERIOD = 18432,
    parameter int ADDR_WIDTH    = 3
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic [NUM_MOTORS*COUNT_WIDTH-1:0] enc_count,
    encoder_velocity_sampler_if.slave         host
);
    localparam int CH_W  = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int TMR_W = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [TMR_W-1:0]       timer;
    logic                   tick;
    logic [CH_W-1:0]        ch;
    logic                   last_ch;
    logic                   capture_en;
    logic                   commit_en;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] prev   [NUM_MOTORS];
    logic [COUNT_WIDTH-1:0] shadow [NUM_MOTORS];
    logic [COUNT_WIDTH-1:0] bank   [NUM_MOTORS];
    logic [COUNT_WIDTH-1:0] rd_sel;
    logic [COUNT_WIDTH-1:0] rd_data_q;
    logic                   sample_valid_q;
    logic [7:0]             seq_q;
    logic                   overrun_q;

    // Ticks are gated by enable so dropping enable can never start a sweep.
    assign tick    = enable && (timer == TMR_W'(SAMPLE_PERIOD - 1));
    assign last_ch = (ch == CH_W'(NUM_MOTORS - 1));
    assign busy    = (state != IDLE);

    // Sample timer: free-running 0..SAMPLE_PERIOD-1, parked at 0 while disabled.
    // NOTE: all state uses non-blocking assignment so every register samples
    // pre-edge values and the result does not depend on process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    timer <= '0;
        else if (!enable || tick) timer <= '0;
        else             timer <= timer + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // FSM next state and per-state strobes.
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_next = state;
        capture_en = 1'b0;
        commit_en  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) state_next = CAPTURE;
            end
            CAPTURE: begin
                capture_en = 1'b1;
                if (last_ch) state_next = COMMIT;
            end
            COMMIT: begin
                if (!host.lock) begin
                    commit_en  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep channel index; returns to 0 after the last channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        ch <= '0;
        else if (capture_en) ch <= last_ch ? '0 : ch + 1'b1;
    end

    // Per-channel delta capture into the shadow set, remembering the raw count.
    // NOTE: the arrays are reset because a reset must restart delta tracking
    // from zero and must not leave a half-swept set visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                prev[i]   <= '0;
                shadow[i] <= '0;
            end
        end else if (capture_en) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (ch == CH_W'(i)) begin
                    shadow[i] <= enc_count[i*COUNT_WIDTH +: COUNT_WIDTH] - prev[i];
                    prev[i]   <= enc_count[i*COUNT_WIDTH +: COUNT_WIDTH];
                end
            end
        end
    end

    // Atomic commit of the whole shadow set into the readout bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MOTORS; i++) bank[i] <= '0;
        end else if (commit_en) begin
            for (int i = 0; i < NUM_MOTORS; i++) bank[i] <= shadow[i];
        end
    end

    // Commit pulse and sequence counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_valid_q <= 1'b0;
            seq_q          <= '0;
        end else begin
            sample_valid_q <= commit_en;
            if (commit_en) seq_q <= seq_q + 8'd1;
        end
    end

    // Sticky overrun: a tick arriving mid-sweep is dropped; set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                overrun_q <= 1'b0;
        else if (tick && busy)       overrun_q <= 1'b1;
        else if (host.ovr_clr)       overrun_q <= 1'b0;
    end

    // Readout mux; unmapped addresses read as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (host.rd_addr == ADDR_WIDTH'(i)) rd_sel = bank[i];
        end
    end

    // Registered readout, one clock behind rd_addr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_data_q <= '0;
        else          rd_data_q <= rd_sel;
    end

    assign host.rd_data      = rd_data_q;
    assign host.sample_valid = sample_valid_q;
    assign host.sample_seq   = seq_q;
    assign host.busy         = busy;
    assign host.overrun      = overrun_q;
endmodule

// File: tb/tb_encoder_velocity_sampler.sv
// Self-checking bench for encoder_velocity_sampler (2 channels, period 16).
// Expected commits are queued when counts are driven and checked on sample_valid.
module tb_encoder_velocity_sampler;
    localparam int NM = 2;
    localparam int CW = 15;
    localparam int SP = 16;
    localparam int AW = 2;

    typedef struct {
        logic [CW-1:0] d0;
        logic [CW-1:0] d1;
        logic [7:0]    seq;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b1;
    logic [NM*CW-1:0] enc_count = '0;

    encoder_velocity_sampler_if #(.COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

    encoder_velocity_sampler #(
        .NUM_MOTORS(NM), .COUNT_WIDTH(CW), .SAMPLE_PERIOD(SP), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .enc_count(enc_count), .host(bus)
    );

    always #5 clk = ~clk;

    int            n_vec  = 0;
    int            n_miss = 0;
    exp_t          sb[$];
    logic [CW-1:0] prev0 = '0;
    logic [CW-1:0] prev1 = '0;
    logic [7:0]    exp_seq = '0;
    logic [CW-1:0] last_d0 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive new counts and queue the commit they should produce.
    task automatic push_expect(input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        exp_t e;
        enc_count = {c1, c0};
        e.d0 = c0 - prev0;
        e.d1 = c1 - prev1;
        exp_seq = exp_seq + 8'd1;
        e.seq = exp_seq;
        prev0 = c0;
        prev1 = c1;
        sb.push_back(e);
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [CW-1:0] exp);
        bus.rd_addr = a;
        @(posedge clk); #1;
        check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic wait_busy(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.busy && n < 64);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    // Wait for a commit, check latency (if exp_lat > 0), sequence and bank contents.
    task automatic await_commit(input string tag, input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.sample_valid && n < 80);
        check({tag, "_valid"}, 32'(bus.sample_valid), 32'd1);
        if (exp_lat > 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_seq"}, 32'(bus.sample_seq), 32'(e.seq));
            read_chk({tag, "_ch0"}, 2'd0, e.d0);
            check({tag, "_pulse"}, 32'(bus.sample_valid), 32'd0);
            read_chk({tag, "_ch1"}, 2'd1, e.d1);
            read_chk({tag, "_oob2"}, 2'd2, '0);
            read_chk({tag, "_oob3"}, 2'd3, '0);
            last_d0 = e.d0;
        end
    endtask

    initial begin
        int n;
        bus.lock    = 1'b0;
        bus.rd_addr = '0;
        bus.ovr_clr = 1'b0;

        // Reset values
        #12;
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_seq", 32'(bus.sample_seq), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);

        // 1. Basic sweep: first commit 19 clocks after reset release
        push_expect(15'd100, 15'd5);
        @(negedge clk);
        reset_n = 1'b1;
        await_commit("basic", SP + 3);

        // 2. Wrap-around in both directions on both channels
        push_expect(15'h7FF0, 15'h0003);
        await_commit("wrap_a", 0);
        push_expect(15'h0010, 15'h7FFE);
        await_commit("wrap_up", 0);
        push_expect(15'h7FF0, 15'h0001);
        await_commit("wrap_dn", 0);

        // 3. Lock held across a tick, released 10 clocks later
        bus.lock = 1'b1;
        push_expect(15'h0123, 15'h0042);
        wait_busy("lock", n);
        bus.rd_addr = 2'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("lock_no_valid", 32'(bus.sample_valid), 32'd0);
            check("lock_bank_hold", 32'(bus.rd_data), 32'(last_d0));
        end
        bus.lock = 1'b0;
        await_commit("lock_rel", 1);
        check("lock_no_ovr", 32'(bus.overrun), 32'd0);

        // 4. Overrun: lock over two ticks, single commit after release
        bus.lock = 1'b1;
        push_expect(15'h0200, 15'h0100);
        wait_busy("ovr", n);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("ovr_no_valid", 32'(bus.sample_valid), 32'd0);
        end
        check("ovr_set", 32'(bus.overrun), 32'd1);
        bus.lock = 1'b0;
        await_commit("ovr_rel", 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("ovr_single", 32'(bus.sample_valid), 32'd0);
        end
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.ovr_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovr_clr = 1'b0;
        check("ovr_clr", 32'(bus.overrun), 32'd0);
        push_expect(15'h0100, 15'h0200);
        await_commit("ovr_next", 0);

        // 5. Enable off for 40 clocks, then exactly 16 clocks to the next tick
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check("dis_no_valid", 32'(bus.sample_valid), 32'd0);
            check("dis_idle", 32'(bus.busy), 32'd0);
        end
        push_expect(15'h0150, 15'h0180);
        enable = 1'b1;
        wait_busy("reen", n);
        check("reen_tick_lat", 32'(n), 32'(SP));
        await_commit("reen", NM + 1);

        // 6. Reset while ch=1 of a sweep
        push_expect(15'h0AAA, 15'h0555);
        bus.rd_addr = 2'd0;
        wait_busy("mid", n);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_rd_data", 32'(bus.rd_data), 32'd0);
        check("midrst_seq", 32'(bus.sample_seq), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.sample_valid), 32'd0);
        sb.delete();
        prev0 = '0;
        prev1 = '0;
        exp_seq = '0;
        @(negedge clk);
        @(negedge clk);
        push_expect(15'h1234, 15'h7FFF);
        reset_n = 1'b1;
        await_commit("post_rst", SP + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
